ahb_lite_mem_slave: RTL and testbench

Zero-wait-state AHB-Lite slave backed by an on-chip word-addressed RAM array. It serves as a behavioural and synthesizable memory target beside the SDRAM controller on the MIPSfpga+ AHB-Lite bus. It is the reference slave for bringing up AHB-Lite master emulation tasks. Every transfer completes in one data-phase cycle with an OKAY response.

---
 rtl/ahb_lite_pkg.sv | 27 ++
 rtl/ahb_lite_be_decode.sv | 19 +
 rtl/ahb_lite_mem_slave.sv | 80 ++++++++
 tb/tb_ahb_lite_mem_slave.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings used by the slaves on the MIPSfpga+ bus.
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_t;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_t;

    // NONSEQ and SEQ are the only transfer types that reach memory.
    function automatic logic is_active_trans(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_lite_be_decode.sv
// Little-endian byte-lane enables for an AHB-Lite transfer of a given size.
module ahb_lite_be_decode (
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] be
);
    import ahb_lite_pkg::*;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        be = 4'b1111;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr_lo;
            HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
    end

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// Zero-wait-state AHB-Lite slave backed by a word-addressed on-chip RAM.
module ahb_lite_mem_slave #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [2:0]  HBURST,
    input  logic        HSEL,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP
);
    import ahb_lite_pkg::*;

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic                  dp_valid;
    logic                  dp_write;
    logic [2:0]            dp_size;
    logic [ADDR_WIDTH+1:0] dp_addr;
    logic [ADDR_WIDTH-1:0] dp_index;
    logic [3:0]            dp_be;
    logic                  accept;
    logic                  wr_en;
    logic [31:0]           mem [DEPTH];

    // Burst type and upper address bits do not affect this slave; the RAM aliases.
    logic unused_inputs;
    assign unused_inputs = ^{HBURST, HADDR[31:ADDR_WIDTH+2]};

    assign HREADY = 1'b1;
    assign HRESP  = HRESP_OKAY;
    assign accept = HSEL && is_active_trans(HTRANS) && HREADY;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_size  <= HSIZE_BYTE;
            dp_addr  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            dp_valid <= accept;
            if (accept) begin
                dp_write <= HWRITE;
                dp_size  <= HSIZE;
                dp_addr  <= HADDR[ADDR_WIDTH+1:0];
            end
        end
    end

    assign dp_index = dp_addr[ADDR_WIDTH+1:2];
    assign wr_en    = dp_valid && dp_write;

    ahb_lite_be_decode u_be_decode (
        .size    (dp_size),
        .addr_lo (dp_addr[1:0]),
        .be      (dp_be)
    );

    // NOTE: the RAM array has no reset; contents stay undefined until written.
    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (dp_be[b]) begin
                    mem[dp_index][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    // Asynchronous read: a read registered at the edge that commits a write sees the new data.
    assign HRDATA = (dp_valid && !dp_write) ? mem[dp_index] : 32'h0;

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Randomized and directed bench for ahb_lite_mem_slave against a byte-level memory model.
module tb_ahb_lite_mem_slave;

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HSEL;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    ahb_lite_mem_slave #(.ADDR_WIDTH(6)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .HADDR   (HADDR),
        .HBURST  (HBURST),
        .HSEL    (HSEL),
        .HSIZE   (HSIZE),
        .HTRANS  (HTRANS),
        .HWDATA  (HWDATA),
        .HWRITE  (HWRITE),
        .HRDATA  (HRDATA),
        .HREADY  (HREADY),
        .HRESP   (HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        bit          valid;
        bit          write;
        int          size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } phase_t;

    int     total = 0;
    int     bad   = 0;
    bit     done  = 0;
    phase_t ph;
    logic [7:0] mem_m [64][4];
    bit         known [64][4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model write: lanes follow from transfer size and the aligned low address bits.
    function automatic void model_write(input logic [31:0] addr, input int size, input logic [31:0] data);
        int n    = (size == 0) ? 1 : (size == 1) ? 2 : 4;
        int lo   = int'(addr[1:0]);
        int base = (n == 4) ? 0 : (lo / n) * n;
        int idx  = int'(addr[7:2]);
        for (int b = base; b < base + n; b++) begin
            mem_m[idx][b] = data[8*b +: 8];
            known[idx][b] = 1'b1;
        end
    endfunction

    function automatic bit model_known(input logic [31:0] addr);
        int idx = int'(addr[7:2]);
        return known[idx][0] && known[idx][1] && known[idx][2] && known[idx][3];
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        int idx = int'(addr[7:2]);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = mem_m[idx][b];
        return w;
    endfunction

    // One bus cycle: present an address phase plus the data of the transfer now in its data phase.
    task automatic beat(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = wr;
        HSIZE  = size;
        HADDR  = addr;
        HBURST = 3'($urandom);
        HWDATA = (ph.valid && ph.write) ? ph.wdata : $urandom;
        @(posedge HCLK);
        if (HRESETn && ph.valid && ph.write) model_write(ph.addr, ph.size, ph.wdata);
        if (HRESETn && sel && trans[1]) begin
            ph.valid = 1'b1;
            ph.write = wr;
            ph.size  = int'(size);
            ph.addr  = addr;
            ph.wdata = wdata;
        end else begin
            ph.valid = 1'b0;
        end
        #1;
    endtask

    task automatic write_word(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] size);
        beat(1'b1, 2'd2, 1'b1, size, addr, data);
    endtask

    task automatic read_expect(input string name, input logic [31:0] addr, input logic [31:0] exp);
        beat(1'b1, 2'd2, 1'b0, 3'd2, addr, 32'h0);
        @(negedge HCLK);
        check(name, HRDATA, exp);
    endtask

    // Continuous compare against the model on every falling edge.
    always @(negedge HCLK) begin
        if (!done) begin
            check("hready", 32'(HREADY), 32'd1);
            check("hresp", 32'(HRESP), 32'd0);
            if (!HRESETn || !ph.valid || ph.write)
                check("hrdata_idle", HRDATA, 32'h0);
            else if (model_known(ph.addr))
                check("hrdata_model", HRDATA, model_word(ph.addr));
        end
    end

    initial begin
        HRESETn = 1'b0;
        HSEL = 1'b0; HTRANS = 2'd0; HWRITE = 1'b0; HSIZE = 3'd0;
        HADDR = 32'h0; HBURST = 3'd0; HWDATA = 32'h0;
        ph.valid = 1'b0; ph.write = 1'b0; ph.size = 0; ph.addr = 32'h0; ph.wdata = 32'h0;
        for (int i = 0; i < 64; i++) for (int b = 0; b < 4; b++) known[i][b] = 1'b0;

        repeat (2) begin
            @(negedge HCLK);
            check("rst_hrdata", HRDATA, 32'h0);
            check("rst_hready", 32'(HREADY), 32'd1);
        end
        @(posedge HCLK);
        #1 HRESETn = 1'b1;

        // Pipelined write/write/read/read/read sequence.
        beat(1'b1, 2'd0, 1'b0, 3'd2, 32'h0, 32'h0);
        write_word(32'h4, 32'd4, 3'd2);
        write_word(32'h8, 32'd8, 3'd2);
        read_expect("pipe_rd4", 32'h4, 32'd4);
        read_expect("pipe_rd8a", 32'h8, 32'd8);
        read_expect("pipe_rd8b", 32'h8, 32'd8);
        beat(1'b1, 2'd0, 1'b0, 3'd2, 32'h0, 32'h0);

        write_word(32'h10, 32'hAABBCCDD, 3'd2);
        write_word(32'h12, 32'h00110000, 3'd0);
        read_expect("byte_write", 32'h10, 32'hAA11CCDD);

        write_word(32'h14, 32'hFFFFFFFF, 3'd2);
        write_word(32'h14, 32'h0000BEEF, 3'd1);
        read_expect("half_write", 32'h14, 32'hFFFFBEEF);

        write_word(32'h100, 32'h12345678, 3'd2);
        read_expect("alias", 32'h0, 32'h12345678);

        beat(1'b0, 2'd2, 1'b1, 3'd2, 32'h4, 32'h0000DEAD);
        beat(1'b1, 2'd1, 1'b1, 3'd2, 32'h4, 32'h0000DEAD);
        read_expect("no_write_unselected", 32'h4, 32'd4);

        read_expect("rd_before_wr", 32'h8, 32'd8);
        write_word(32'h8, 32'h00000099, 3'd2);
        read_expect("wr_after_rd", 32'h8, 32'h00000099);

        // Fill every word so the model can predict all random reads.
        for (int i = 0; i < 64; i++) write_word(32'(i * 4), $urandom, 3'd2);
        for (int i = 0; i < 600; i++) begin
            beat(($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom),
                 3'($urandom_range(0, 3)), $urandom, $urandom);
        end
        beat(1'b0, 2'd0, 1'b0, 3'd2, 32'h0, 32'h0);

        // Reset during a write data phase must abort the write.
        write_word(32'h20, 32'h0BADCAFE, 3'd2);
        write_word(32'h20, 32'h5555AAAA, 3'd2);
        HSEL = 1'b0;
        HTRANS = 2'd0;
        HWDATA = 32'h5555AAAA;
        #2 HRESETn = 1'b0;
        ph.valid = 1'b0;
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        read_expect("rst_abort", 32'h20, 32'h0BADCAFE);
        beat(1'b0, 2'd0, 1'b0, 3'd2, 32'h0, 32'h0);

        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
